sym_seq_tx: RTL and testbench



---
 rtl/sym_seq_pkg.sv | 6 +
 rtl/sym_seq_tx_sym_buf.sv | 20 ++
 rtl/sym_seq_tx.sv | 109 ++++++++++
 tb/tb_sym_seq_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sym_seq_pkg.sv
// sym_seq_pkg: shared state encoding and symbol constants for the symbol sequence transmitter
package sym_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FIN = 2'd2} state_t;
    localparam int SYM_W = 2;
    localparam logic [SYM_W-1:0] IDLE_SYM_DEF = 2'b00;
endpackage

// File: rtl/sym_seq_tx_sym_buf.sv
// sym_buf: DEPTH x 2-bit pattern store, one write port, asynchronous read, no reset
module sym_buf
    import sym_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [SYM_W-1:0] wd,
    input  logic [AW-1:0]    ra,
    output logic [SYM_W-1:0] rd
);
    logic [SYM_W-1:0] mem [DEPTH];
    // contents survive reset so a pattern can be replayed after an abort
    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;
    assign rd = mem[ra];
endmodule

// File: rtl/sym_seq_tx.sv
// sym_seq_tx: replays len symbols from a pattern buffer, HOLD cycles each; SYM_SEQ_TX_REPEAT_EN adds looping
module sym_seq_tx
    import sym_seq_pkg::*;
#(
    parameter int               DEPTH    = 16,
    parameter int               AW       = 4,
    parameter int               HOLD     = 1,
    parameter logic [SYM_W-1:0] IDLE_SYM = IDLE_SYM_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [SYM_W-1:0] wr_data,
    input  logic             start,
    input  logic [AW:0]      len,
`ifdef SYM_SEQ_TX_REPEAT_EN
    input  logic             repeat_mode,
`endif
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    output logic             busy,
    output logic             done,
    output logic             wr_err
);
    localparam int            HW        = HOLD > 1 ? $clog2(HOLD) : 1;
    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    state_t           state;
    logic [AW-1:0]    idx;
    logic [AW:0]      len_q;
    logic [HW-1:0]    hold_cnt;
    logic [SYM_W-1:0] rd_data;
    logic [AW-1:0]    rd_addr;
    logic             more;
    logic             wrap;

    assign more    = ({1'b0, idx} + (AW+1)'(1)) < len_q;
    // in IDLE and on a wrap the next symbol is entry 0, otherwise the one after idx
    assign rd_addr = (state == SEND && more) ? idx + AW'(1) : '0;
`ifdef SYM_SEQ_TX_REPEAT_EN
    assign wrap = repeat_mode;
`else
    assign wrap = 1'b0;
`endif

    sym_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk (clk),
        .we  (wr_en && state != SEND),
        .wa  (wr_addr),
        .wd  (wr_data),
        .ra  (rd_addr),
        .rd  (rd_data)
    );

    // transmit FSM; every output is loaded here so all of them are registered
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            sym_out   <= IDLE_SYM;
            sym_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_err    <= 1'b0;
            idx       <= '0;
            hold_cnt  <= '0;
            len_q     <= '0;
        end else begin
            wr_err <= wr_en && state == SEND;
            done   <= 1'b0;
            case (state)
                IDLE:
                    if (start) begin
                        len_q    <= len > DEPTH_L ? DEPTH_L : len;
                        idx      <= '0;
                        hold_cnt <= '0;
                        if (len != '0) begin
                            state     <= SEND;
                            sym_out   <= rd_data;
                            sym_valid <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                SEND:
                    if (hold_cnt != HOLD_LAST)
                        hold_cnt <= hold_cnt + HW'(1);
                    else begin
                        hold_cnt <= '0;
                        if (more || wrap) begin
                            idx     <= more ? idx + AW'(1) : '0;
                            sym_out <= rd_data;
                        end else begin
                            state     <= FIN;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            sym_valid <= 1'b0;
                            sym_out   <= IDLE_SYM;
                            idx       <= '0;
                        end
                    end
                default:
                    state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_sym_seq_tx.sv
// tb_sym_seq_tx: scoreboard bench driving a HOLD=1 and a HOLD=2 transmitter with the same stimulus
module tb_sym_seq_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [1:0] wr_data;
    logic       start;
    logic [4:0] len;
`ifdef SYM_SEQ_TX_REPEAT_EN
    logic       repeat_mode;
`endif
    logic [1:0] sym_out, sym_out2;
    logic       sym_valid, sym_valid2, busy, busy2, done, done2, wr_err, wr_err2;

    logic [1:0] tbuf [16];
    logic [1:0] exp_q[$];
    logic [1:0] exp2_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sym_seq_tx #(.DEPTH(16), .AW(4), .HOLD(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len),
`ifdef SYM_SEQ_TX_REPEAT_EN
        .repeat_mode(repeat_mode),
`endif
        .sym_out(sym_out), .sym_valid(sym_valid), .busy(busy), .done(done), .wr_err(wr_err)
    );

    sym_seq_tx #(.DEPTH(16), .AW(4), .HOLD(2)) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len),
`ifdef SYM_SEQ_TX_REPEAT_EN
        .repeat_mode(repeat_mode),
`endif
        .sym_out(sym_out2), .sym_valid(sym_valid2), .busy(busy2), .done(done2), .wr_err(wr_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (!reset) begin
            if (sym_valid) begin
                if (exp_q.size() == 0) chk("sym1_extra", exp_q.size(), 1);
                else chk("sym1", sym_out, exp_q.pop_front());
            end
            if (sym_valid2) begin
                if (exp2_q.size() == 0) chk("sym2_extra", exp2_q.size(), 1);
                else chk("sym2", sym_out2, exp2_q.pop_front());
            end
        end

    task automatic wr(input int a, input logic [1:0] d);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        tbuf[a] = d;
    endtask

    // act: 0 plain, 1 write addr 1 mid-run, 2 second start mid-run, 3 write addr 0 = 3 on the start edge
    task automatic run(input int l, input int act);
        int lq, b1, b2, d1, d2, n1, n2, e1, e2;
        lq = l > 16 ? 16 : l;
        for (int i = 0; i < lq; i++) begin
            exp_q.push_back(tbuf[i]);
            exp2_q.push_back(tbuf[i]);
            exp2_q.push_back(tbuf[i]);
        end
        len = 5'(l); start = 1'b1;
        if (act == 3) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 2'd3; tbuf[0] = 2'd3;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        b1 = 0; b2 = 0; d1 = -1; d2 = -1; n1 = 0; n2 = 0; e1 = 0; e2 = 0;
        for (int c = 1; c <= 2*lq + 4; c++) begin
            if (busy) b1++;
            if (busy2) b2++;
            if (done) begin n1++; if (d1 < 0) d1 = c; end
            if (done2) begin n2++; if (d2 < 0) d2 = c; end
            if (wr_err) e1++;
            if (wr_err2) e2++;
            if (c == 1 && act == 1) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = ~tbuf[1];
            end
            if (c == 1 && act == 2) begin
                start = 1'b1; len = 5'd1;
            end
            if (c == 2) begin wr_en = 1'b0; start = 1'b0; end
            @(negedge clk);
        end
        chk($sformatf("busy1_len%0d", l), b1, lq);
        chk($sformatf("busy2_len%0d", l), b2, 2*lq);
        chk($sformatf("done1_at_len%0d", l), d1, lq + 1);
        chk($sformatf("done2_at_len%0d", l), d2, 2*lq + 1);
        chk("done1_pulses", n1, 1);
        chk("done2_pulses", n2, 1);
        chk("wr_err1_pulses", e1, act == 1 ? 1 : 0);
        chk("wr_err2_pulses", e2, act == 1 ? 1 : 0);
        chk("q1_drained", exp_q.size(), 0);
        chk("q2_drained", exp2_q.size(), 0);
        chk("idle_sym1", sym_out, 0);
        chk("idle_sym2", sym_out2, 0);
        exp_q.delete();
        exp2_q.delete();
    endtask

    initial begin
        int nd;
        reset = 1'b1; wr_en = 1'b0; start = 1'b0; len = '0; wr_addr = '0; wr_data = '0;
`ifdef SYM_SEQ_TX_REPEAT_EN
        repeat_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sym", sym_out, 0);
        chk("rst_valid", sym_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_busy2", busy2, 0);
        for (int i = 0; i < 16; i++) wr(i, 2'($urandom_range(0, 3)));
        wr(0, 2'd2); wr(1, 2'd3); wr(2, 2'd0); wr(3, 2'd1);
        run(4, 0);
        wr(0, 2'd3); wr(1, 2'd1);
        run(2, 0);
        run(0, 0);
        run(20, 0);
        run(4, 1);
        run(4, 0);
        run(4, 2);
        wr(0, 2'd1);
        run(4, 3);
        run(4, 0);
        // abort mid-run with reset: outputs clear at once and no done follows
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(tbuf[i]);
            exp2_q.push_back(tbuf[i]);
            exp2_q.push_back(tbuf[i]);
        end
        len = 5'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_valid", sym_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sym", sym_out, 0);
        chk("abort_busy2", busy2, 0);
        exp_q.delete();
        exp2_q.delete();
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || done2) nd++;
        end
        chk("abort_no_done", nd, 0);
        run(4, 0);
`ifdef SYM_SEQ_TX_REPEAT_EN
        begin
            int b1, b2, d1, d2;
            for (int p = 0; p < 3; p++) begin
                exp_q.push_back(tbuf[0]); exp_q.push_back(tbuf[1]);
            end
            for (int p = 0; p < 2; p++) begin
                exp2_q.push_back(tbuf[0]); exp2_q.push_back(tbuf[0]);
                exp2_q.push_back(tbuf[1]); exp2_q.push_back(tbuf[1]);
            end
            repeat_mode = 1'b1; len = 5'd2; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            b1 = 0; b2 = 0; d1 = -1; d2 = -1;
            for (int c = 1; c <= 14; c++) begin
                if (busy) b1++;
                if (busy2) b2++;
                if (done && d1 < 0) d1 = c;
                if (done2 && d2 < 0) d2 = c;
                if (c == 5) repeat_mode = 1'b0;
                @(negedge clk);
            end
            chk("rpt_busy1", b1, 6);
            chk("rpt_busy2", b2, 8);
            chk("rpt_done1_at", d1, 7);
            chk("rpt_done2_at", d2, 9);
            chk("rpt_q1_drained", exp_q.size(), 0);
            chk("rpt_q2_drained", exp2_q.size(), 0);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
